// File: rtl/alu_exec_unit.sv
// ALU execution stage: decode, single-cycle ops, iterative MULTU (and DIVU).
// Build option: define ALU_DIVIDER_EN to add the DIVU restoring divider.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  localparam int SHAMT_W = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            alu_op,
  input  logic [5:0]            alu_funct,
  input  logic [SHAMT_W-1:0]    shamt,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  zero,
  output logic                  illegal_op,
  output logic                  busy
);

  localparam int W = DATA_WIDTH;
  localparam logic [SHAMT_W-1:0] CNT_INIT = SHAMT_W'(W - 1);

`ifdef ALU_DIVIDER_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;
`else
  typedef enum logic [0:0] {
    S_IDLE,
    S_MUL
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]         mcand_q, mcand_d;
  logic [2*W-1:0]       prod_q, prod_d;
  logic [W-1:0]         result_q, result_d;
  logic [W-1:0]         hi_q, hi_d;
  logic                 zero_q, zero_d;
  logic                 ill_q, ill_d;
  logic                 valid_q, valid_d;

  logic [W-1:0]         dec_res;
  logic                 dec_ill;
  logic                 dec_mul;
  logic                 dec_div;

  logic [W:0]           mul_sum;
  logic [2*W-1:0]       mul_next;
`ifdef ALU_DIVIDER_EN
  logic [W:0]           div_sh;
  logic [W:0]           div_try;
  logic [2*W-1:0]       div_next;
`endif

  // Decode {alu_op, alu_funct} and compute every single-cycle result.
  always_comb begin
    dec_res = '0;
    dec_ill = 1'b0;
    dec_mul = 1'b0;
    dec_div = 1'b0;
    unique case (alu_op)
      3'b111: begin
        unique case (alu_funct)
          6'b100100: dec_res = operand_a & operand_b;
          6'b100101: dec_res = operand_a | operand_b;
          6'b100111: dec_res = ~(operand_a | operand_b);
          6'b100000: dec_res = operand_a + operand_b;
          6'b100010: dec_res = operand_a - operand_b;
          6'b000000: dec_res = operand_b << shamt;
          6'b000010: dec_res = operand_b >> shamt;
          6'b011001: dec_mul = 1'b1;
`ifdef ALU_DIVIDER_EN
          6'b011011: dec_div = 1'b1;
`endif
          default:   dec_ill = 1'b1;
        endcase
      end
      3'b100:  dec_res = operand_a + operand_b;
      3'b101:  dec_res = operand_a | operand_b;
      3'b110:  dec_res = operand_a & operand_b;
      3'b010:  dec_res = {operand_b[W-17:0], 16'h0};
      default: dec_ill = 1'b1;
    endcase
  end

  // One shift-add multiply step: {hi,lo} holds partial product and multiplier.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*W-1:W]}
             + ({1'b0, mcand_q} & {(W+1){prod_q[0]}});
    mul_next = {mul_sum, prod_q[W-1:1]};
  end

`ifdef ALU_DIVIDER_EN
  // One restoring divide step: {hi,lo} holds remainder and dividend/quotient.
  always_comb begin
    div_sh  = {prod_q[2*W-1:W], prod_q[W-1]};
    div_try = div_sh - {1'b0, mcand_q};
    if (!div_try[W])
      div_next = {div_try[W-1:0], prod_q[W-2:0], 1'b1};
    else
      div_next = {div_sh[W-1:0], prod_q[W-2:0], 1'b0};
  end
`endif

  // Next-state and output register update for the execution FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    ill_d    = ill_q;
    valid_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (dec_mul) begin
            state_d = S_MUL;
            cnt_d   = CNT_INIT;
            mcand_d = operand_a;
            prod_d  = {{W{1'b0}}, operand_b};
          end
`ifdef ALU_DIVIDER_EN
          else if (dec_div) begin
            if (operand_b == '0) begin
              valid_d  = 1'b1;
              result_d = '1;
              hi_d     = operand_a;
              zero_d   = 1'b0;
              ill_d    = 1'b0;
            end else begin
              state_d = S_DIV;
              cnt_d   = CNT_INIT;
              mcand_d = operand_b;
              prod_d  = {{W{1'b0}}, operand_a};
            end
          end
`endif
          else begin
            valid_d  = 1'b1;
            result_d = dec_res;
            hi_d     = '0;
            zero_d   = (dec_res == '0);
            ill_d    = dec_ill;
          end
        end
      end
      S_MUL: begin
        prod_d = mul_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          valid_d  = 1'b1;
          result_d = mul_next[W-1:0];
          hi_d     = mul_next[2*W-1:W];
          zero_d   = (mul_next[W-1:0] == '0);
          ill_d    = 1'b0;
        end
      end
`ifdef ALU_DIVIDER_EN
      S_DIV: begin
        prod_d = div_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          valid_d  = 1'b1;
          result_d = div_next[W-1:0];
          hi_d     = div_next[2*W-1:W];
          zero_d   = (div_next[W-1:0] == '0);
          ill_d    = 1'b0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      ill_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      ill_q    <= ill_d;
      valid_q  <= valid_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = valid_q;
  assign result     = result_q;
  assign result_hi  = hi_q;
  assign zero       = zero_q;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (DATA_WIDTH=32).
// Random and directed ops compared against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    alu_op;
  logic [5:0]    alu_funct;
  logic [4:0]    shamt;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic          out_valid;
  logic [W-1:0]  result;
  logic [W-1:0]  result_hi;
  logic          zero;
  logic          illegal_op;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .alu_funct  (alu_funct),
    .shamt      (shamt),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .out_valid  (out_valid),
    .result     (result),
    .result_hi  (result_hi),
    .zero       (zero),
    .illegal_op (illegal_op),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: what the operation means arithmetically, and how long it takes.
  task automatic model(input logic [2:0] op, input logic [5:0] f,
                       input logic [4:0] sh, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] lo,
                       output logic [W-1:0] hi, output logic ill,
                       output int lat);
    logic [63:0] p;
    lo = '0; hi = '0; ill = 1'b0; lat = 0;
    if (op == 3'b100) lo = a + b;
    else if (op == 3'b101) lo = a | b;
    else if (op == 3'b110) lo = a & b;
    else if (op == 3'b010) lo = b * 32'h10000;
    else if (op == 3'b111) begin
      if (f == 6'h24) lo = a & b;
      else if (f == 6'h25) lo = a | b;
      else if (f == 6'h27) lo = ~(a | b);
      else if (f == 6'h20) lo = a + b;
      else if (f == 6'h22) lo = a - b;
      else if (f == 6'h00) lo = b << sh;
      else if (f == 6'h02) lo = b >> sh;
      else if (f == 6'h19) begin
        p = {32'h0, a} * {32'h0, b};
        lo = p[31:0]; hi = p[63:32]; lat = W;
      end
`ifdef ALU_DIVIDER_EN
      else if (f == 6'h1b) begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; lat = W; end
      end
`endif
      else ill = 1'b1;
    end else ill = 1'b1;
  endtask

  // Issue one op (inputs driven #1 after posedge) and check its result.
  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [5:0] f, input logic [4:0] sh,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit junk);
    logic [W-1:0] lo, hi;
    logic ill;
    int lat, cyc;
    model(op, f, sh, a, b, lo, hi, ill, lat);
    check({tag, ".rdy"}, in_ready, 1);
    alu_op = op; alu_funct = f; shamt = sh;
    operand_a = a; operand_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (lat > 0) begin
      check({tag, ".busy"}, busy, 1);
      check({tag, ".nrdy"}, in_ready, 0);
    end
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (junk && cyc < 20) begin
        in_valid = 1'b1; alu_op = 3'b100;
        operand_a = $urandom; operand_b = $urandom;
      end else in_valid = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, ".lat"}, cyc, lat);
    check({tag, ".res"}, result, lo);
    check({tag, ".hi"}, result_hi, hi);
    check({tag, ".zero"}, zero, (lo == 0));
    check({tag, ".ill"}, illegal_op, ill);
    @(posedge clk); #1;
    check({tag, ".pulse"}, out_valid, 0);
  endtask

  localparam int NOPS = 13;
  logic [2:0] tab_op [NOPS] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                                3'b111, 3'b111, 3'b111, 3'b111, 3'b100,
                                3'b101, 3'b110, 3'b010};
  logic [5:0] tab_f  [NOPS] = '{6'h24, 6'h25, 6'h27, 6'h20, 6'h22, 6'h00,
                                6'h02, 6'h19, 6'h1b, 6'h00, 6'h00,
                                6'h00, 6'h00};

  initial begin
    int seen;
    int k;
    logic [W-1:0] ra, rb;
    reset = 1'b1; in_valid = 1'b0; alu_op = '0; alu_funct = '0;
    shamt = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst.rdy", in_ready, 1);
    check("rst.vld", out_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.res", result, 0);
    check("rst.hi", result_hi, 0);
    check("rst.ill", illegal_op, 0);
    check("rst.zero", zero, 1);

    do_op("add", 3'b111, 6'h20, 0, 32'hFFFF_FFFF, 32'h2, 0);
    check("add.k", result, 32'h1);
    do_op("sub", 3'b111, 6'h22, 0, 32'h5, 32'h5, 0);
    do_op("sll", 3'b111, 6'h00, 31, 0, 32'h1, 0);
    check("sll.k", result, 32'h8000_0000);
    do_op("srl", 3'b111, 6'h02, 31, 0, 32'h8000_0000, 0);
    check("srl.k", result, 32'h1);
    do_op("lui", 3'b010, 6'h3f, 0, 32'h9, 32'h0000_1234, 0);
    check("lui.k", result, 32'h1234_0000);
    do_op("illg", 3'b111, 6'h3f, 0, 32'h7, 32'h9, 0);
    do_op("multu", 3'b111, 6'h19, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    check("multu.hk", result_hi, 32'hFFFF_FFFE);
    do_op("divu", 3'b111, 6'h1b, 0, 32'd100, 32'd7, 0);
    do_op("div0", 3'b111, 6'h1b, 0, 32'd55, 32'd0, 0);

    // Back-to-back ORI then NOR on consecutive edges.
    alu_op = 3'b101; operand_a = 32'hF0; operand_b = 32'h0F; in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b.v1", out_valid, 1);
    check("b2b.r1", result, 32'hFF);
    alu_op = 3'b111; alu_funct = 6'h27;
    operand_a = 32'h0F0F_0000; operand_b = 32'h0000_00FF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b.v2", out_valid, 1);
    check("b2b.r2", result, 32'hF0F0_FF00);
    @(posedge clk); #1;
    check("b2b.v3", out_valid, 0);

    // Reset in the middle of a MULTU: no result pulse afterwards.
    alu_op = 3'b111; alu_funct = 6'h19;
    operand_a = 32'h1234; operand_b = 32'h5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mrst.rdy", in_ready, 1);
    check("mrst.busy", busy, 0);
    check("mrst.res", result, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("mrst.nov", seen, 0);

    for (int i = 0; i < 150; i++) begin
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = $urandom_range(0, 9);
      if ($urandom_range(0, 4) == 0) begin
        do_op("rnd", 3'($urandom), 6'($urandom), 5'($urandom),
              ra, rb, 0);
      end else begin
        k = $urandom_range(0, NOPS - 1);
        do_op("rnd", tab_op[k], tab_f[k], 5'($urandom), ra, rb, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
